// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by initiators and slaves in this codebase.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Sizes wider than the 32-bit bus are issued as word transfers.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'd2) ? HSIZE_WORD : s;
  endfunction

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: valid/ready command stream to pipelined single transfers,
// one response per command, with wait-state and two-cycle ERROR handling.
module ahb_lite_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [2:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic          HMASTLOCK,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA,
  input  logic          HRESP
);

  logic          a_valid_q;
  logic [AW-1:0] a_addr_q;
  logic          a_write_q;
  logic [2:0]    a_size_q;
  logic [31:0]   a_wdata_q;

  logic          d_valid_q;
  logic          d_write_q;
  logic [31:0]   d_wdata_q;

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q,   rsp_err_d;

  logic err_now;
  logic accept;
  logic complete;
  logic handshake;

  // First ERROR cycle cancels the pending address phase; it is retried once the error completes.
  assign err_now   = d_valid_q & (HRESP == HRESP_ERROR);
  assign accept    = a_valid_q & HREADY & ~err_now;
  assign complete  = d_valid_q & HREADY;
  assign cmd_ready = ~a_valid_q | (HREADY & ~err_now);
  assign handshake = cmd_valid & cmd_ready;

  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HTRANS    = (a_valid_q & ~err_now) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWDATA    = d_wdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign busy      = a_valid_q | d_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
    end else if (handshake) begin
      a_valid_q <= 1'b1;
      a_addr_q  <= cmd_addr;
      a_write_q <= cmd_write;
      a_size_q  <= clamp_size(cmd_size);
      a_wdata_q <= cmd_wdata;
    end else if (accept) begin
      a_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
    end else if (accept) begin
      d_valid_q <= 1'b1;
      d_write_q <= a_write_q;
      d_wdata_q <= a_wdata_q;
    end else if (complete) begin
      d_valid_q <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = complete;
    rsp_err_d   = complete & HRESP;
    rsp_rdata_d = '0;
    if (complete && !d_write_q && HRESP == HRESP_OKAY) begin
      rsp_rdata_d = HRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
